// File: rtl/sram_rw0_arbiter.sv
// rw0 port arbiter for the packet-buffer SRAM: zero-fills the array after reset,
// then round-robins requesters A and B onto the macro with a 2-stage read tag pipe.
module sram_rw0_arbiter #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 384,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASK  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [BITS-1:0]       a_wdata,
  input  logic [NUM_WMASK-1:0]  a_wmask,
  output logic                  a_rvalid,
  output logic [BITS-1:0]       a_rdata,
  output logic                  a_err,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [BITS-1:0]       b_wdata,
  input  logic [NUM_WMASK-1:0]  b_wmask,
  output logic                  b_rvalid,
  output logic [BITS-1:0]       b_rdata,
  output logic                  b_err,
  output logic                  init_done,
  output logic                  rw0_ce_in,
  output logic                  rw0_we_in,
  output logic [ADDR_WIDTH-1:0] rw0_addr_in,
  output logic [BITS-1:0]       rw0_wd_in,
  output logic [NUM_WMASK-1:0]  rw0_wmask_in,
  input  logic [BITS-1:0]       rw0_rd_out
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam int STAGES = 2;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef struct packed {
    logic b_side;
    logic rd;
    logic legal;
  } tag_t;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  ptr_b;
  logic                  grant_a, grant_b, acc, legal;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BITS-1:0]       req_wdata;
  logic [NUM_WMASK-1:0]  req_wmask;
  tag_t                  cur_tag, resp;
  logic [STAGES:1]       vld_pipe;
  tag_t                  tag_pipe [STAGES:1];
  logic                  resp_vld;

  // Single requester always wins; on contention the pointer side wins.
  assign grant_a = a_valid & (~b_valid | ~ptr_b);
  assign grant_b = b_valid & (~a_valid |  ptr_b);
  assign a_ready = init_done & grant_a;
  assign b_ready = init_done & grant_b;
  assign acc     = a_ready | b_ready;

  assign req_we    = a_ready ? a_we    : b_we;
  assign req_addr  = a_ready ? a_addr  : b_addr;
  assign req_wdata = a_ready ? a_wdata : b_wdata;
  assign req_wmask = a_ready ? a_wmask : b_wmask;
  assign legal     = (req_addr <= LAST);

  assign cur_tag = '{b_side: b_ready, rd: ~req_we, legal: legal};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      init_addr    <= '0;
      init_done    <= 1'b0;
      ptr_b        <= 1'b0;
      rw0_ce_in    <= 1'b0;
      rw0_we_in    <= 1'b0;
      rw0_addr_in  <= '0;
      rw0_wd_in    <= '0;
      rw0_wmask_in <= '0;
      vld_pipe     <= '0;
      for (int s = 1; s <= STAGES; s++) tag_pipe[s] <= '0;
    end else begin
      vld_pipe[1] <= acc;
      tag_pipe[1] <= cur_tag;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
      // Lags RUN by one cycle so init_done rises after the last fill command.
      init_done <= init_done | (state == S_RUN);
      case (state)
        S_INIT: begin
          rw0_ce_in    <= 1'b1;
          rw0_we_in    <= 1'b1;
          rw0_addr_in  <= init_addr;
          rw0_wd_in    <= '0;
          rw0_wmask_in <= '1;
          init_addr    <= init_addr + 1'b1;
          if (init_addr == LAST) state <= S_RUN;
        end
        default: begin
          if (acc) ptr_b <= a_ready;
          // Idle and out-of-range cycles drive all-zero so the macro never sees X.
          if (acc && legal) begin
            rw0_ce_in    <= 1'b1;
            rw0_we_in    <= req_we;
            rw0_addr_in  <= req_addr;
            rw0_wd_in    <= req_wdata;
            rw0_wmask_in <= req_wmask;
          end else begin
            rw0_ce_in    <= 1'b0;
            rw0_we_in    <= 1'b0;
            rw0_addr_in  <= '0;
            rw0_wd_in    <= '0;
            rw0_wmask_in <= '0;
          end
        end
      endcase
    end
  end

  assign resp_vld = vld_pipe[STAGES];
  assign resp     = tag_pipe[STAGES];

  assign a_rvalid = resp_vld & ~resp.b_side & resp.rd;
  assign a_err    = resp_vld & ~resp.b_side & ~resp.legal;
  assign a_rdata  = (a_rvalid & resp.legal) ? rw0_rd_out : '0;
  assign b_rvalid = resp_vld &  resp.b_side & resp.rd;
  assign b_err    = resp_vld &  resp.b_side & ~resp.legal;
  assign b_rdata  = (b_rvalid & resp.legal) ? rw0_rd_out : '0;

endmodule

// File: tb/tb_sram_rw0_arbiter.sv
// Bench for sram_rw0_arbiter: behavioural read-first byte-masked macro plus a
// scoreboard of expected responses checked by an independent monitor.
module tb_sram_rw0_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
  logic [8:0]  a_addr = 0, b_addr = 0;
  logic [31:0] a_wdata = 0, b_wdata = 0;
  logic [3:0]  a_wmask = 0, b_wmask = 0;
  logic        a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err, init_done;
  logic [31:0] a_rdata, b_rdata;
  logic        rw0_ce_in, rw0_we_in;
  logic [8:0]  rw0_addr_in;
  logic [31:0] rw0_wd_in, rw0_rd_out;
  logic [3:0]  rw0_wmask_in;

  sram_rw0_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_wmask(a_wmask), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_wmask(b_wmask), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .init_done(init_done),
    .rw0_ce_in(rw0_ce_in), .rw0_we_in(rw0_we_in), .rw0_addr_in(rw0_addr_in),
    .rw0_wd_in(rw0_wd_in), .rw0_wmask_in(rw0_wmask_in), .rw0_rd_out(rw0_rd_out)
  );

  always #5 clk = ~clk;

  // Macro model: read-first, byte-masked, read data valid the cycle after sampling.
  logic [31:0] mem [384];
  initial for (int i = 0; i < 384; i++) mem[i] = 32'hA5A5_0000 | i;
  always @(posedge clk) begin
    if (rw0_ce_in && rw0_addr_in < 9'd384) begin
      if (!rw0_we_in) rw0_rd_out <= mem[rw0_addr_in];
      else
        for (int k = 0; k < 4; k++)
          if (rw0_wmask_in[k]) mem[rw0_addr_in][8*k +: 8] <= rw0_wd_in[8*k +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int ce_cnt = 0;
  always @(negedge clk) if (rw0_ce_in) ce_cnt++;

  typedef struct {
    int          cyc;
    logic        a_rv, a_er, b_rv, b_er;
    logic [31:0] a_rd, b_rd;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  bit exp_ptr_b = 0;

  // Monitor: pops one expected response per strobe cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL resp_missing: expected response at cycle %0d never seen", sb[0].cyc);
      void'(sb.pop_front());
    end
    if (a_rvalid | a_err | b_rvalid | b_err) begin
      tests++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        fails++;
        $display("FAIL resp_unexpected: cyc %0d a_rv=%b a_err=%b b_rv=%b b_err=%b", cyc, a_rvalid, a_err, b_rvalid, b_err);
      end else begin
        if ({a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata} !==
            {sb[0].a_rv, sb[0].a_er, sb[0].a_rd, sb[0].b_rv, sb[0].b_er, sb[0].b_rd}) begin
          fails++;
          $display("FAIL resp_data: cyc %0d got a(rv=%b err=%b d=%h) b(rv=%b err=%b d=%h) want a(rv=%b err=%b d=%h) b(rv=%b err=%b d=%h)",
                   cyc, a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata,
                   sb[0].a_rv, sb[0].a_er, sb[0].a_rd, sb[0].b_rv, sb[0].b_er, sb[0].b_rd);
        end
        void'(sb.pop_front());
      end
    end else if (init_done) begin
      tests++;
      if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
        fails++;
        $display("FAIL rdata_idle: a_rdata=%h b_rdata=%h want 0", a_rdata, b_rdata);
      end
    end
  end

  function automatic exp_t mk_exp(input bit side, input bit rv, input bit er, input logic [31:0] d, input int c);
    exp_t e;
    e.cyc = c;
    e.a_rv = side ? 1'b0 : rv;  e.a_er = side ? 1'b0 : er;  e.a_rd = side ? 32'h0 : d;
    e.b_rv = side ? rv : 1'b0;  e.b_er = side ? er : 1'b0;  e.b_rd = side ? d : 32'h0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input bit side, input bit we, input logic [8:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, input bit push, input logic [31:0] exp_rd);
    bit done = 0;
    if (!side) begin a_valid = 1; a_we = we; a_addr = addr; a_wdata = wd; a_wmask = wm; end
    else       begin b_valid = 1; b_we = we; b_addr = addr; b_wdata = wd; b_wmask = wm; end
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      done = side ? b_ready : a_ready;
      @(posedge clk); #1;
      if (done) begin
        exp_ptr_b = ~side;
        if (push && addr >= 9'd384) sb.push_back(mk_exp(side, ~we, 1'b1, 32'h0, cyc + 1));
        else if (push && !we)       sb.push_back(mk_exp(side, 1'b1, 1'b0, exp_rd, cyc + 1));
      end
      @(negedge clk);
    end
    a_valid = 0; b_valid = 0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL accept_timeout: side %0d addr %0d never accepted", side, addr);
    end
  endtask

  initial begin
    int bad, n, c0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid, a_err, b_err, init_done, rw0_ce_in, rw0_we_in} !== 9'b0 ||
        rw0_addr_in !== 9'h0 || rw0_wd_in !== 32'h0 || rw0_wmask_in !== 4'h0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: ce=%b we=%b addr=%h init_done=%b ready=%b%b want all 0",
               rw0_ce_in, rw0_we_in, rw0_addr_in, init_done, a_ready, b_ready);
    end
    rst = 0;
    @(posedge clk);
    bad = 0;
    for (int i = 0; i < 384; i++) begin
      @(negedge clk);
      if (!(rw0_ce_in === 1'b1 && rw0_we_in === 1'b1 && rw0_wmask_in === 4'hF && rw0_wd_in === 32'h0 &&
            rw0_addr_in === 9'(i) && init_done === 1'b0)) begin
        if (bad == 0)
          $display("FAIL init_seq: step %0d ce=%b we=%b mask=%h wd=%h addr=%0d done=%b want 1 1 f 0 %0d 0",
                   i, rw0_ce_in, rw0_we_in, rw0_wmask_in, rw0_wd_in, rw0_addr_in, init_done, i);
        bad++;
      end
    end
    tests++;
    if (bad != 0) fails++;
    @(negedge clk);
    tests++;
    if (init_done !== 1'b1) begin fails++; $display("FAIL init_done_rise: got %b want 1", init_done); end

    issue(0, 0, 9'd0,   32'h0, 4'h0, 1, 32'h0);
    issue(0, 0, 9'd200, 32'h0, 4'h0, 1, 32'h0);
    issue(1, 0, 9'd383, 32'h0, 4'h0, 1, 32'h0);

    issue(0, 1, 9'd5, 32'hDEADBEEF, 4'hF, 1, 32'h0);
    issue(1, 0, 9'd5, 32'h0,        4'h0, 1, 32'hDEADBEEF);

    // Both requesters held valid: grants must alternate starting at the pointer side.
    a_valid = 1; a_we = 0; a_addr = 9'd200;
    b_valid = 1; b_we = 0; b_addr = 9'd383;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests++;
      if ({a_ready, b_ready} !== (exp_ptr_b ? 2'b01 : 2'b10)) begin
        fails++;
        $display("FAIL rr_grant: step %0d ready(a,b)=%b%b want %b", k, a_ready, b_ready, exp_ptr_b ? 2'b01 : 2'b10);
      end
      @(posedge clk); #1;
      sb.push_back(mk_exp(exp_ptr_b, 1'b1, 1'b0, 32'h0, cyc + 1));
      exp_ptr_b = ~exp_ptr_b;
      @(negedge clk);
    end
    a_valid = 0; b_valid = 0;

    issue(0, 1, 9'd9, 32'h11223344, 4'hF, 1, 32'h0);
    issue(1, 1, 9'd9, 32'hAABBCCDD, 4'b0101, 1, 32'h0);
    issue(0, 0, 9'd9, 32'h0, 4'h0, 1, 32'h11BB33DD);
    issue(1, 1, 9'd9, 32'hFFFFFFFF, 4'h0, 1, 32'h0);
    issue(1, 0, 9'd9, 32'h0, 4'h0, 1, 32'h11BB33DD);

    repeat (2) @(negedge clk);
    c0 = ce_cnt;
    issue(0, 0, 9'd384, 32'h0, 4'h0, 1, 32'h0);
    issue(1, 1, 9'd511, 32'h12345678, 4'hF, 1, 32'h0);
    repeat (3) @(negedge clk);
    tests++;
    if (ce_cnt != c0) begin fails++; $display("FAIL oor_no_access: ce cycles %0d want 0", ce_cnt - c0); end

    // Read in flight when rst hits: response must be dropped, memory re-zeroed.
    issue(0, 1, 9'd10, 32'hCAFEF00D, 4'hF, 1, 32'h0);
    issue(0, 0, 9'd10, 32'h0, 4'h0, 0, 32'h0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_ptr_b = 0;
    n = 0;
    for (int k = 1; k <= 600 && n == 0; k++) begin
      @(negedge clk);
      if (init_done) n = k;
    end
    tests++;
    if (n != 385) begin fails++; $display("FAIL reinit_len: init_done after %0d cycles want 385", n); end
    issue(1, 0, 9'd10, 32'h0, 4'h0, 1, 32'h0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d responses outstanding want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
